laser_arbiter: RTL and testbench

Round-robin controller that shares one laser output between `N_REQ` requesters. It grants one requester at a time, drives the shared laser enable `X` for that requester's programmed pulse length, then holds a fixed cooldown before granting again. It sits between the user-facing button/request logic and the laser driver. It replaces per-user single-shot laser timers with one arbitrated, sequenced resource.

---
 rtl/laser_arbiter_if.sv | 16 +
 rtl/laser_arbiter.sv | 119 +++++++++++
 tb/tb_laser_arbiter.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/laser_arbiter_if.sv
// Request/grant bundle between the requester logic and laser_arbiter.
// The master drives Req/Dur; the slave (the arbiter) returns Grant/X/Busy/Done.
interface laser_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int DUR_W = 4
);
  logic [N_REQ-1:0]       Req;
  logic [N_REQ*DUR_W-1:0] Dur;
  logic [N_REQ-1:0]       Grant;
  logic                   X;
  logic                   Busy;
  logic                   Done;

  modport master (output Req, Dur, input Grant, X, Busy, Done);
  modport slave  (input Req, Dur, output Grant, X, Busy, Done);
endinterface

// File: rtl/laser_arbiter.sv
// Round-robin owner of one shared laser: grant, fire for Dur cycles, cool down.
// Optional macro LASER_ARB_ABORT_EN: dropping the owner's Req ends its pulse early.
module laser_arbiter #(
  parameter int N_REQ    = 4,
  parameter int DUR_W    = 4,
  parameter int COOLDOWN = 2
) (
  input  logic           Clk,
  input  logic           Rst,
  laser_arbiter_if.slave bus
);
  localparam int CW = (DUR_W > 4) ? DUR_W : 4;
  localparam int LW = $clog2(N_REQ);
  localparam logic [CW-1:0] COOL_LD = (COOLDOWN > 0) ? CW'(COOLDOWN - 1) : '0;

  typedef enum logic [1:0] {IDLE, FIRE, COOL} state_t;

  state_t                 state;
  logic [CW-1:0]          cnt;
  logic [LW-1:0]          last;
  logic [N_REQ-1:0]       grant;
  logic                   x, busy, done;

  logic [DUR_W-1:0]       dur_a [N_REQ];
  logic [LW-1:0]          win;
  logic                   found;
  logic [DUR_W-1:0]       dsel;
  logic [CW-1:0]          eff_m1;
  logic                   fire_end;
  int                     idx;

  for (genvar i = 0; i < N_REQ; i++) begin : g_dur
    assign dur_a[i] = bus.Dur[i*DUR_W +: DUR_W];
  end

  // Search starts one past the previous winner and wraps, so every
  // requester gets a turn before anyone is served twice.
  always_comb begin
    win   = last;
    found = 1'b0;
    idx   = 0;
    for (int off = 1; off <= N_REQ; off++) begin
      idx = (int'(last) + off) % N_REQ;
      if (!found && bus.Req[idx]) begin
        found = 1'b1;
        win   = LW'(idx);
      end
    end
  end

  // A zero duration still fires for one cycle.
  always_comb begin
    dsel   = dur_a[win];
    eff_m1 = (dsel == '0) ? '0 : CW'(dsel) - CW'(1);
  end

`ifdef LASER_ARB_ABORT_EN
  assign fire_end = (cnt == '0) || !bus.Req[last];
`else
  assign fire_end = (cnt == '0);
`endif

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= IDLE;
      cnt   <= '0;
      last  <= LW'(N_REQ - 1);
      grant <= '0;
      x     <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            last  <= win;
            grant <= N_REQ'(1) << win;
            cnt   <= eff_m1;
            x     <= 1'b1;
            busy  <= 1'b1;
            state <= FIRE;
          end
        end
        FIRE: begin
          if (!fire_end) begin
            cnt <= cnt - CW'(1);
          end else begin
            x     <= 1'b0;
            grant <= '0;
            done  <= 1'b1;
            if (COOLDOWN > 0) begin
              state <= COOL;
              cnt   <= COOL_LD;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
              cnt   <= '0;
            end
          end
        end
        COOL: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.Grant = grant;
  assign bus.X     = x;
  assign bus.Busy  = busy;
  assign bus.Done  = done;
endmodule

// File: tb/tb_laser_arbiter.sv
// Bench for laser_arbiter: directed table, corner sequences, then random traffic
// against a schedule-based reference model.
module tb_laser_arbiter;
  localparam int N = 4;
  localparam int DW = 4;
  localparam int C = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  laser_arbiter_if #(.N_REQ(N), .DUR_W(DW)) bus ();

  laser_arbiter #(.N_REQ(N), .DUR_W(DW), .COOLDOWN(C)) dut (
    .Clk(clk), .Rst(rst), .bus(bus.slave)
  );

  always #5 clk = ~clk;

  // Reference: each grant is a schedule (start edge, length); outputs are
  // derived from where the current edge falls inside that schedule.
  int n = 0;
  int m_last = N - 1;
  int free_at = 0;
  bit have = 0;
  int g_start = 0, g_eff = 0, g_idx = 0;

  task automatic model_edge(input logic r, input logic [N-1:0] q, input logic [N*DW-1:0] d);
    int w, e;
    logic [DW-1:0] f;
    n++;
    if (r) begin
      m_last = N - 1; free_at = n + 1; have = 0;
    end else if (n >= free_at && q != '0) begin
      w = -1;
      for (int off = 1; off <= N; off++)
        if (w < 0 && q[(m_last + off) % N]) w = (m_last + off) % N;
      f = d[w*DW +: DW];
      e = (f == 0) ? 1 : int'(f);
      g_start = n; g_eff = e; g_idx = w; have = 1;
      m_last = w; free_at = n + e + C + 1;
    end
  endtask

  function automatic logic exp_x();
    return have && n >= g_start && n < g_start + g_eff;
  endfunction
  function automatic logic exp_busy();
    return have && n >= g_start && n < g_start + g_eff + C;
  endfunction
  function automatic logic exp_done();
    return have && n == g_start + g_eff;
  endfunction
  function automatic logic [N-1:0] exp_grant();
    logic [N-1:0] g;
    g = '0;
    if (exp_x()) g[g_idx] = 1'b1;
    return g;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", name, n, act, req);
    end
  endtask

  task automatic tick(input logic r, input logic [N-1:0] q, input logic [N*DW-1:0] d);
    rst = r; bus.Req = q; bus.Dur = d;
    @(posedge clk);
    model_edge(r, q, d);
    #1;
  endtask

  typedef struct {
    logic           r;
    logic [N-1:0]   q;
    logic [15:0]    d;
    logic           x;
    logic [N-1:0]   g;
    logic           b;
    logic           dn;
  } vec_t;

  vec_t tbl [11];
  logic [N-1:0] rr_g [5];
  int           rr_t [5];
  logic [N-1:0] rr_exp [5];
  logic [N-1:0] prev_g;
  logic [N-1:0] rq;
  logic [15:0]  rd;
  int got, xcnt;

  initial begin
    bus.Req = '0; bus.Dur = '0;
    // Dur 16'h1013: Dur0=3, Dur1=1, Dur2=0, Dur3=1
    tbl[0]  = '{1'b1, 4'hF, 16'h1013, 1'b0, 4'h0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 4'hF, 16'h1013, 1'b1, 4'h1, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 4'h0, 16'h1013, 1'b1, 4'h1, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 4'h0, 16'h1013, 1'b1, 4'h1, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 4'h0, 16'h1013, 1'b0, 4'h0, 1'b1, 1'b1};
    tbl[5]  = '{1'b0, 4'h0, 16'h1013, 1'b0, 4'h0, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 4'h0, 16'h1013, 1'b0, 4'h0, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 4'h4, 16'h1013, 1'b1, 4'h4, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 4'h0, 16'h1013, 1'b0, 4'h0, 1'b1, 1'b1};
    tbl[9]  = '{1'b0, 4'h0, 16'h1013, 1'b0, 4'h0, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 4'h0, 16'h1013, 1'b0, 4'h0, 1'b0, 1'b0};

    for (int i = 0; i < 11; i++) begin
      tick(tbl[i].r, tbl[i].q, tbl[i].d);
      chk($sformatf("tbl%0d_x", i), 32'(bus.X), 32'(tbl[i].x));
      chk($sformatf("tbl%0d_grant", i), 32'(bus.Grant), 32'(tbl[i].g));
      chk($sformatf("tbl%0d_busy", i), 32'(bus.Busy), 32'(tbl[i].b));
      chk($sformatf("tbl%0d_done", i), 32'(bus.Done), 32'(tbl[i].dn));
    end

    // Round robin: all requesting, Dur=1, grants 4 edges apart.
    rr_exp[0] = 4'h1; rr_exp[1] = 4'h2; rr_exp[2] = 4'h4; rr_exp[3] = 4'h8; rr_exp[4] = 4'h1;
    tick(1'b1, 4'h0, 16'h1111);
    got = 0; prev_g = '0;
    for (int t = 0; t < 40 && got < 5; t++) begin
      tick(1'b0, 4'hF, 16'h1111);
      if (bus.Grant != '0 && prev_g == '0) begin
        rr_g[got] = bus.Grant; rr_t[got] = t; got++;
      end
      prev_g = bus.Grant;
    end
    chk("rr_count", 32'(got), 32'd5);
    for (int i = 0; i < got; i++) begin
      chk($sformatf("rr_grant%0d", i), 32'(rr_g[i]), 32'(rr_exp[i]));
      if (i > 0) chk($sformatf("rr_gap%0d", i), 32'(rr_t[i] - rr_t[i-1]), 32'd4);
    end

    // Mid-pulse reset: priority restarts at requester 0, no Done.
    tick(1'b1, 4'h0, 16'h1115);
    tick(1'b0, 4'h3, 16'h1115);
    chk("mrst_g1", 32'(bus.Grant), 32'h1);
    tick(1'b0, 4'h3, 16'h1115);
    chk("mrst_x2", 32'(bus.X), 32'h1);
    tick(1'b1, 4'h3, 16'h1115);
    chk("mrst_x", 32'(bus.X), 32'h0);
    chk("mrst_done", 32'(bus.Done), 32'h0);
    chk("mrst_busy", 32'(bus.Busy), 32'h0);
    tick(1'b0, 4'h3, 16'h1115);
    chk("mrst_regrant", 32'(bus.Grant), 32'h1);
    tick(1'b0, 4'h3, 16'h1115);
    chk("mrst_done2", 32'(bus.Done), 32'h0);

    // Abort sequence: Dur1=6, Req[1] dropped after two X cycles.
    tick(1'b1, 4'h0, 16'h1161);
    tick(1'b0, 4'h2, 16'h1161);
    chk("abt_grant", 32'(bus.Grant), 32'h2);
    tick(1'b0, 4'h2, 16'h1161);
    tick(1'b0, 4'h0, 16'h1161);
`ifdef LASER_ARB_ABORT_EN
    chk("abt_x", 32'(bus.X), 32'h0);
    chk("abt_done", 32'(bus.Done), 32'h1);
`else
    chk("abt_x", 32'(bus.X), 32'h1);
    xcnt = 3;
    for (int t = 0; t < 20 && bus.X; t++) begin
      tick(1'b0, 4'h0, 16'h1161);
      if (bus.X) xcnt++;
    end
    chk("abt_len", 32'(xcnt), 32'd6);
    chk("abt_done", 32'(bus.Done), 32'h1);
`endif

    // Random traffic against the model; the owner's Req is held through
    // its pulse so the abort build behaves identically here.
    tick(1'b1, 4'h0, 16'h0);
    for (int t = 0; t < 600; t++) begin
      rq = 4'($urandom);
      if ($urandom_range(3) == 0) rq = '0;
      rd = 16'($urandom);
      if (have && n + 1 <= g_start + g_eff) rq[g_idx] = 1'b1;
      tick(($urandom_range(40) == 0), rq, rd);
      chk("rnd_x", 32'(bus.X), 32'(exp_x()));
      chk("rnd_grant", 32'(bus.Grant), 32'(exp_grant()));
      chk("rnd_busy", 32'(bus.Busy), 32'(exp_busy()));
      chk("rnd_done", 32'(bus.Done), 32'(exp_done()));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
